// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared types and helpers for the FFT frame sequencer
//
// Purpose: sequencer state encoding, RAM write-mux select encoding and the
// bit-reversal helper used for LOAD addressing.
// Ports: none (package).
package fft_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_RD_V,
        S_RD_U,
        S_MUL,
        S_ADD,
        S_WR_U,
        S_WR_V,
        S_DRAIN_RD,
        S_DRAIN_OUT,
        S_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        WSEL_SMP = 2'd0,
        WSEL_U   = 2'd1,
        WSEL_V   = 2'd2
    } ram_wsel_e;

    // Reverse the low n bits of val. Each pass shifts the next source bit in
    // at the bottom, so after n passes val[0] sits at bit n-1.
    function automatic logic [31:0] bit_reverse(input logic [31:0] val, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r = {r[30:0], val[i[4:0]]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// rtl/fft_seq_ctrl_if.sv - sample/result handshake bundle of the FFT sequencer
//
// Purpose: groups the input-sample and output-result handshakes.
// Signals: smp_valid_i/smp_ready_o (sample load), res_valid_o/res_ready_i/
// res_last_o (result drain). master = sequencer side, slave = environment side.
interface fft_seq_ctrl_if;

    logic smp_valid_i;
    logic smp_ready_o;
    logic res_valid_o;
    logic res_ready_i;
    logic res_last_o;

    modport master (
        input  smp_valid_i,
        input  res_ready_i,
        output smp_ready_o,
        output res_valid_o,
        output res_last_o
    );

    modport slave (
        output smp_valid_i,
        output res_ready_i,
        input  smp_ready_o,
        input  res_valid_o,
        input  res_last_o
    );

endinterface

// File: rtl/fft_seq_ctrl_bf_index_gen.sv
// rtl/fft_seq_ctrl_bf_index_gen.sv - stage/group/butterfly counters and u/v/k indices
//
// Purpose: walks every butterfly of a radix-2 DIT FFT, butterfly index fastest,
// then group, then stage, and presents the RAM indices u, v and twiddle index k.
// Ports: clk_i, rst_ni (async active-low), clr (sync clear), adv (step to next
// butterfly); u, v, k, stage, last_bf (last butterfly of stage), last_all
// (last butterfly of the frame).
module fft_bf_index_gen #(
    parameter  int FFT_SIZE = 16,
    localparam int ADDR_W   = $clog2(FFT_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] u,
    output logic [ADDR_W-1:0] v,
    output logic [ADDR_W-1:0] k,
    output logic [ADDR_W-1:0] stage,
    output logic              last_bf,
    output logic              last_all
);

    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] g;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] b_last;
    logic [ADDR_W-1:0] g_last;

    always_comb begin
        half     = ADDR_W'(1) << s;
        b_last   = half - ADDR_W'(1);
        g_last   = ADDR_W'(FFT_SIZE >> (int'(s) + 1)) - ADDR_W'(1);
        u        = (g << (int'(s) + 1)) + b;
        v        = u + half;
        k        = b << (ADDR_W - 1 - int'(s));
        last_bf  = (b == b_last) && (g == g_last);
        last_all = last_bf && (s == ADDR_W'(ADDR_W - 1));
    end

    assign stage = s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s <= '0;
            g <= '0;
            b <= '0;
        end else if (clr) begin
            s <= '0;
            g <= '0;
            b <= '0;
        end else if (adv) begin
            if (b != b_last) begin
                b <= b + ADDR_W'(1);
            end else begin
                b <= '0;
                if (g != g_last) begin
                    g <= g + ADDR_W'(1);
                end else begin
                    g <= '0;
                    // Counters return to zero after the final butterfly so the
                    // next frame starts clean without an explicit clear.
                    s <= last_all ? '0 : s + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - LOAD/COMPUTE/DRAIN frame sequencer for an in-place radix-2 FFT
//
// Purpose: owns the shared single-port RAM (1-cycle read latency) and sequences
// bit-reversed sample writes, six-cycle butterflies and natural-order readout.
// Ports: clk_i, rst_ni (async active-low), start_i, abort_i; hs (sample/result
// handshakes); ram_we_o, ram_addr_o, ram_wsel_o (RAM control); tw_addr_o
// (twiddle index); ld_v_o, ld_u_o, ld_bf_o (datapath enables); stage_o,
// busy_o, done_o (status).
module fft_seq_ctrl
    import fft_seq_pkg::*;
#(
    parameter  int FFT_SIZE = 16,
    localparam int ADDR_W   = $clog2(FFT_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    fft_seq_ctrl_if.master    hs,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [1:0]        ram_wsel_o,
    output logic [ADDR_W-1:0] tw_addr_o,
    output logic              ld_v_o,
    output logic              ld_u_o,
    output logic              ld_bf_o,
    output logic [ADDR_W-1:0] stage_o,
    output logic              busy_o,
    output logic              done_o
);

    generate
        if (FFT_SIZE < 4 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_size
            $error("FFT_SIZE must be a power of 2 and at least 4");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(FFT_SIZE - 1);

    seq_state_e        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_rev;
    logic [ADDR_W-1:0] bf_u;
    logic [ADDR_W-1:0] bf_v;
    logic [ADDR_W-1:0] bf_k;
    logic [ADDR_W-1:0] bf_stage;
    logic              stage_end_unused;
    logic              frame_end;
    logic              idx_clr;
    logic              idx_adv;
    ram_wsel_e         wsel;

    assign cnt_rev = ADDR_W'(bit_reverse(32'(cnt), ADDR_W));
    assign idx_clr = abort_i || (state == S_IDLE);
    assign idx_adv = !abort_i && (state == S_WR_V);

    fft_bf_index_gen #(
        .FFT_SIZE (FFT_SIZE)
    ) u_index_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (idx_clr),
        .adv      (idx_adv),
        .u        (bf_u),
        .v        (bf_v),
        .k        (bf_k),
        .stage    (bf_stage),
        .last_bf  (stage_end_unused),
        .last_all (frame_end)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (abort_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_i) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (hs.smp_valid_i) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_RD_V;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
                S_RD_V:  state <= S_RD_U;
                S_RD_U:  state <= S_MUL;
                S_MUL:   state <= S_ADD;
                S_ADD:   state <= S_WR_U;
                S_WR_U:  state <= S_WR_V;
                S_WR_V:  state <= frame_end ? S_DRAIN_RD : S_RD_V;
                S_DRAIN_RD: state <= S_DRAIN_OUT;
                S_DRAIN_OUT: begin
                    if (hs.res_ready_i) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt + ADDR_W'(1);
                            state <= S_DRAIN_RD;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the registered state; abort masks every
    // write, load and valid in the same cycle it is raised.
    always_comb begin
        ram_we_o       = 1'b0;
        ram_addr_o     = '0;
        wsel           = WSEL_SMP;
        tw_addr_o      = '0;
        ld_v_o         = 1'b0;
        ld_u_o         = 1'b0;
        ld_bf_o        = 1'b0;
        done_o         = 1'b0;
        hs.smp_ready_o = 1'b0;
        hs.res_valid_o = 1'b0;
        hs.res_last_o  = 1'b0;
        if (!abort_i) begin
            case (state)
                S_LOAD: begin
                    hs.smp_ready_o = 1'b1;
                    ram_we_o       = hs.smp_valid_i;
                    ram_addr_o     = cnt_rev;
                end
                S_RD_V: ram_addr_o = bf_v;
                S_RD_U: begin
                    ram_addr_o = bf_u;
                    tw_addr_o  = bf_k;
                    ld_v_o     = 1'b1;
                end
                S_MUL: ld_u_o = 1'b1;
                S_ADD: ld_bf_o = 1'b1;
                S_WR_U: begin
                    ram_we_o   = 1'b1;
                    ram_addr_o = bf_u;
                    wsel       = WSEL_U;
                end
                S_WR_V: begin
                    ram_we_o   = 1'b1;
                    ram_addr_o = bf_v;
                    wsel       = WSEL_V;
                end
                S_DRAIN_RD: ram_addr_o = cnt;
                S_DRAIN_OUT: begin
                    ram_addr_o     = cnt;
                    hs.res_valid_o = 1'b1;
                    hs.res_last_o  = (cnt == CNT_LAST);
                end
                S_DONE: done_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign ram_wsel_o = wsel;
    assign stage_o    = bf_stage;
    assign busy_o     = (state != S_IDLE);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - scoreboard bench for the FFT frame sequencer
module tb_fft_seq_ctrl;

    localparam int N         = 16;
    localparam int AW        = 4;
    localparam int BF_CYCLES = 6 * (N / 2) * AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [1:0]    wsel;
    logic [AW-1:0] tw_addr;
    logic          ld_v, ld_u, ld_bf;
    logic [AW-1:0] stage;
    logic          busy, done;

    fft_seq_ctrl_if hs();

    fft_seq_ctrl #(.FFT_SIZE(N)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .hs         (hs),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_wsel_o (wsel),
        .tw_addr_o  (tw_addr),
        .ld_v_o     (ld_v),
        .ld_u_o     (ld_u),
        .ld_bf_o    (ld_bf),
        .stage_o    (stage),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int wsel; } wr_t;
    typedef struct { int u; int v; int k; int s; } bf_t;

    wr_t wq[$];
    bf_t bq[$];
    int  rq[$];
    int  dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frame_id = 0;

    int i_addr, i_tw, i_stage, i_wsel;
    assign i_addr  = int'(ram_addr);
    assign i_tw    = int'(tw_addr);
    assign i_stage = int'(stage);
    assign i_wsel  = int'(wsel);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rev(input int x);
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    // Reference frame: bit-reversed loads, then every butterfly in
    // stage/group/butterfly order writing u then v, then natural readout.
    task automatic push_frame();
        frame_id++;
        for (int i = 0; i < N; i++) wq.push_back('{rev(i), 0});
        for (int s = 0; s < AW; s++)
            for (int g = 0; g < N / (2 ** (s + 1)); g++)
                for (int b = 0; b < 2 ** s; b++) begin
                    int u = g * (2 ** (s + 1)) + b;
                    int v = u + 2 ** s;
                    bq.push_back('{u, v, b * (2 ** (AW - 1 - s)), s});
                    wq.push_back('{u, 1});
                    wq.push_back('{v, 2});
                end
        for (int i = 0; i < N; i++) rq.push_back(i);
        dq.push_back(1);
    endtask

    function automatic int outs();
        return 32'({ram_we, ram_addr, wsel, tw_addr, ld_v, ld_u, ld_bf, stage,
                    busy, done, hs.smp_ready_o, hs.res_valid_o, hs.res_last_o});
    endfunction

    // Monitor
    wr_t w_exp;
    bf_t b_exp;
    int  r_exp;
    int  mon_fid = -1, last_load = -1, t_ldv = -1, last_acc = -1, p_addr = 0;
    bit  seen_res = 0, p_valid = 0, p_ready = 0, p_ldv = 0, p_ldu = 0, p_we = 0, p_done = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mon_fid != frame_id) begin
                mon_fid   = frame_id;
                last_load = -1;
                t_ldv     = -1;
                seen_res  = 0;
            end
            if (ram_we) begin
                if (wq.size() == 0) check(0, "unexpected_write", i_addr, -1);
                else begin
                    w_exp = wq.pop_front();
                    check(i_addr == w_exp.addr, "write_addr", i_addr, w_exp.addr);
                    check(i_wsel == w_exp.wsel, "write_sel", i_wsel, w_exp.wsel);
                    if (w_exp.wsel == 0) last_load = cyc;
                end
            end
            if (ld_v) begin
                if (bq.size() == 0) check(0, "unexpected_butterfly", i_addr, -1);
                else begin
                    b_exp = bq.pop_front();
                    check(i_addr == b_exp.u, "rdu_addr", i_addr, b_exp.u);
                    check(i_tw == b_exp.k, "twiddle_idx", i_tw, b_exp.k);
                    check(i_stage == b_exp.s, "stage", i_stage, b_exp.s);
                    check(p_addr == b_exp.v && !p_we, "rdv_addr", p_addr, b_exp.v);
                    if (t_ldv < 0) begin
                        t_ldv = cyc;
                        check(last_load >= 0 && cyc == last_load + 2, "load_to_rdv", cyc - last_load, 2);
                    end
                end
            end
            if (ld_u)  check(p_ldv, "mul_after_rdu", int'(p_ldv), 1);
            if (ld_bf) check(p_ldu, "add_after_mul", int'(p_ldu), 1);
            if (ld_v || ld_u || ld_bf || (ram_we && wsel != 2'd0) || hs.res_valid_o)
                check(!hs.smp_ready_o, "ready_outside_load", int'(hs.smp_ready_o), 0);
            if (p_valid && !p_ready && !abort) begin
                check(hs.res_valid_o, "valid_hold", int'(hs.res_valid_o), 1);
                check(i_addr == p_addr, "addr_hold", i_addr, p_addr);
            end
            if (hs.res_valid_o && !seen_res) begin
                seen_res = 1;
                check(t_ldv >= 0 && cyc - t_ldv == BF_CYCLES, "compute_length", cyc - t_ldv, BF_CYCLES);
            end
            if (hs.res_last_o)
                check(hs.res_valid_o && i_addr == N - 1, "last_qualify", i_addr, N - 1);
            if (hs.res_valid_o && hs.res_ready_i) begin
                if (rq.size() == 0) check(0, "unexpected_result", i_addr, -1);
                else begin
                    r_exp = rq.pop_front();
                    check(i_addr == r_exp, "drain_addr", i_addr, r_exp);
                    check(hs.res_last_o == (r_exp == N - 1), "drain_last", int'(hs.res_last_o), int'(r_exp == N - 1));
                    last_acc = cyc;
                end
            end
            if (done) begin
                if (dq.size() == 0) check(0, "unexpected_done", 1, 0);
                else begin
                    void'(dq.pop_front());
                    check(cyc == last_acc + 1, "done_timing", cyc - last_acc, 1);
                end
            end
            if (p_done) check(!busy, "busy_after_done", int'(busy), 0);
        end
        p_valid = hs.res_valid_o;
        p_ready = hs.res_ready_i;
        p_ldv   = ld_v;
        p_ldu   = ld_u;
        p_we    = ram_we;
        p_done  = done;
        p_addr  = i_addr;
    end

    task automatic do_abort();
        abort          = 1'b1;
        start          = 1'b0;
        hs.smp_valid_i = 1'b0;
        wq.delete();
        bq.delete();
        rq.delete();
        dq.delete();
        frame_id++;
        @(negedge clk);
        check({ram_we, ld_v, ld_u, ld_bf, hs.res_valid_o, done} == 6'b0, "abort_cycle_outputs",
              int'({ram_we, ld_v, ld_u, ld_bf, hs.res_valid_o, done}), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check(!busy, "idle_after_abort", int'(busy), 0);
    endtask

    task automatic run_frame(input bit directed, input int abort_at);
        int acc = 0, guard = 0, nbf = 0, hold = 0;
        bit held = 0, got_done = 0;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (acc < N && guard < 200) begin
            hs.smp_valid_i = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (hs.smp_valid_i && hs.smp_ready_o) acc++;
            @(posedge clk); #1;
            guard++;
        end
        check(acc == N, "load_accepts", acc, N);
        guard = 0;
        while (!hs.res_valid_o && guard < 400) begin
            start          = ($urandom_range(0, 7) == 0);
            hs.smp_valid_i = $urandom_range(0, 1) != 0;
            if (abort_at > 0 && ld_bf) begin
                nbf++;
                if (nbf == abort_at) begin
                    @(posedge clk); #1;
                    do_abort();
                    return;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        start          = 1'b0;
        hs.smp_valid_i = 1'b0;
        check(guard < 400, "compute_timeout", guard, 400);
        guard = 0;
        while (!got_done && guard < 300) begin
            if (directed && hs.res_valid_o && i_addr == 3 && !held) begin
                hold = 5;
                held = 1;
            end
            hs.res_ready_i = (hold > 0) ? 1'b0 : (directed ? 1'b1 : ($urandom_range(0, 2) != 0));
            if (hold > 0) hold--;
            @(negedge clk);
            if (done) got_done = 1;
            @(posedge clk); #1;
            guard++;
        end
        hs.res_ready_i = 1'b0;
        check(got_done, "done_seen", int'(got_done), 1);
        if (directed) check(held, "drain_hold_applied", int'(held), 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        hs.smp_valid_i = 1'b0;
        hs.res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(outs() == 0, "reset_idle_outputs", outs(), 0);
        end
        run_frame(1, 0);
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check(!busy, "start_with_abort", int'(busy), 0);
        run_frame(0, int'($urandom_range(1, 32)));
        run_frame(0, 0);
        run_frame(0, int'($urandom_range(1, 32)));
        run_frame(0, 0);
        run_frame(1, 0);
        repeat (3) @(posedge clk);
        check(wq.size() == 0, "writes_left", wq.size(), 0);
        check(bq.size() == 0, "butterflies_left", bq.size(), 0);
        check(rq.size() == 0, "results_left", rq.size(), 0);
        check(dq.size() == 0, "dones_left", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time bound at cycle %0d", cyc);
        $fatal(1, "time bound exceeded");
    end

endmodule
